// File: rtl/unidade_controle_multiciclo.sv
// rtl/unidade_controle_multiciclo.sv - multicycle RISC-V control FSM (Moore, registered outputs)
// Optional macro MEM_WAIT_EN: MEM and WB_LOAD hold until mem_ready is sampled high.
module unidade_controle_multiciclo #(
    parameter int CNT_W     = 16,
    parameter int MAX_INSTR = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       estado,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             pcsrc,
    output logic             regiwrite,
    output logic             memtoreg,
    output logic             memread,
    output logic             memwrite,
    output logic             alusrc,
    output logic [1:0]       aluop,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0000,
        S_FETCH  = 4'b0001,
        S_DECODE = 4'b0011,
        S_EXEC   = 4'b0010,
        S_MEM    = 4'b0100,
        S_WB     = 4'b0101,
        S_BRANCH = 4'b0110,
        S_PCINC  = 4'b0111,
        S_HALT   = 4'b1111
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_END = 7'b0000000;

    state_t           r_state;
    state_t           w_next;
    logic             r_is_lw, r_is_r, r_illegal;
    logic [CNT_W-1:0] r_count;
    logic             w_is_lw, w_is_r, w_taken, w_bad_f3;
    logic             w_retire, w_set_illegal, w_cnt_sat, w_mem_go;
    logic [CNT_W-1:0] w_cnt_inc;

    logic       w_irwrite, w_pcwrite, w_pcsrc, w_regiwrite, w_memtoreg;
    logic       w_memread, w_memwrite, w_alusrc, w_halted;
    logic [1:0] w_aluop;

`ifdef MEM_WAIT_EN
    assign w_mem_go = mem_ready;
`else
    logic w_unused;
    assign w_unused = mem_ready;
    assign w_mem_go = 1'b1;
`endif

    assign w_taken   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
    assign w_bad_f3  = (funct3 != 3'b000) && (funct3 != 3'b001);
    assign w_cnt_sat = &r_count;
    assign w_cnt_inc = w_cnt_sat ? r_count : r_count + 1'b1;

    // Instruction class is taken live from the IR while in DECODE, latched copy afterwards.
    always_comb begin
        w_is_lw = r_is_lw;
        w_is_r  = r_is_r;
        if (r_state == S_DECODE) begin
            w_is_lw = (opcode == OP_LW);
            w_is_r  = (opcode == OP_R);
        end
    end

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_I:   w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEM;
                    OP_BR:        w_next = S_BRANCH;
                    OP_END:       w_next = S_HALT;
                    default: begin
                        w_next        = S_HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC:   w_next = S_PCINC;
            S_MEM:    if (w_mem_go) w_next = r_is_lw ? S_WB : S_PCINC;
            S_WB:     if (w_mem_go) w_next = S_PCINC;
            S_BRANCH: begin
                if (w_bad_f3) begin
                    w_next        = S_HALT;
                    w_set_illegal = 1'b1;
                end else if (w_taken) begin
                    w_retire = 1'b1;
                end else begin
                    w_next = S_PCINC;
                end
            end
            S_PCINC:  w_retire = 1'b1;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
        // Retiring the instruction that reaches the limit ends the program.
        if (w_retire) begin
            w_next = S_FETCH;
            if ((MAX_INSTR != 0) && !w_cnt_sat && (w_cnt_inc == CNT_W'(MAX_INSTR)))
                w_next = S_HALT;
        end
    end

    // Outputs decoded from the next state so they land in the same register update.
    always_comb begin
        w_irwrite   = 1'b0;
        w_pcwrite   = 1'b0;
        w_pcsrc     = 1'b0;
        w_regiwrite = 1'b0;
        w_memtoreg  = 1'b0;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_alusrc    = 1'b0;
        w_aluop     = 2'b00;
        w_halted    = 1'b0;
        case (w_next)
            S_FETCH:  w_irwrite = 1'b1;
            S_EXEC: begin
                w_regiwrite = 1'b1;
                w_aluop     = w_is_r ? 2'b10 : 2'b11;
                w_alusrc    = !w_is_r;
            end
            S_MEM: begin
                w_alusrc   = 1'b1;
                w_memread  = w_is_lw;
                w_memwrite = !w_is_lw;
            end
            S_WB: begin
                w_regiwrite = 1'b1;
                w_memtoreg  = 1'b1;
                w_memread   = 1'b1;
            end
            S_BRANCH: begin
                w_aluop   = 2'b01;
                w_pcwrite = w_taken;
                w_pcsrc   = w_taken;
            end
            S_PCINC:  w_pcwrite = 1'b1;
            S_HALT:   w_halted  = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_is_lw   <= 1'b0;
            r_is_r    <= 1'b0;
            r_illegal <= 1'b0;
            r_count   <= '0;
            irwrite   <= 1'b0;
            pcwrite   <= 1'b0;
            pcsrc     <= 1'b0;
            regiwrite <= 1'b0;
            memtoreg  <= 1'b0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            alusrc    <= 1'b0;
            aluop     <= 2'b00;
            halted    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_is_lw   <= w_is_lw;
            r_is_r    <= w_is_r;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_retire) r_count <= w_cnt_inc;
            irwrite   <= w_irwrite;
            pcwrite   <= w_pcwrite;
            pcsrc     <= w_pcsrc;
            regiwrite <= w_regiwrite;
            memtoreg  <= w_memtoreg;
            memread   <= w_memread;
            memwrite  <= w_memwrite;
            alusrc    <= w_alusrc;
            aluop     <= w_aluop;
            halted    <= w_halted;
        end
    end

    assign estado      = r_state;
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule
